// File: rtl/example_word_aligner_pkg.sv
// Shared definitions for the word aligner: FSM encodings, K28.5 encodings, window helpers.
// The comma constants are also used by the TX-side comma inserter.
package example_word_aligner_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;

  localparam int LOCK_COUNT_DEF   = 4;
  localparam int UNLOCK_COUNT_DEF = 3;
  localparam int MAX_GAP_DEF      = 64;

  // Candidate k starts k bits after the first (oldest) bit of the 20-bit window.
  function automatic logic [9:0] cand_at(input logic [19:0] win, input logic [3:0] k);
    logic [19:0] s;
    s = win >> (5'd10 - {1'b0, k});
    return s[9:0];
  endfunction

  function automatic logic is_comma(input logic [9:0] w);
    return (w == COMMA_NEG) || (w == COMMA_POS);
  endfunction

endpackage

// File: rtl/example_comma_finder.sv
// Combinational K28.5 search over the ten bit offsets of a 20-bit window.
// Zero latency; reports the smallest matching offset when several match.
module example_comma_finder
  import example_word_aligner_pkg::*;
(
  input  logic [19:0] i_win,
  output logic        o_hit,
  output logic [3:0]  o_k
);

  logic [9:0] w_match;

  genvar g;
  generate
    for (g = 0; g < 10; g++) begin : g_cmp
      assign w_match[g] = is_comma(i_win[19-g -: 10]);
    end
  endgenerate

  always_comb begin
    o_hit = |w_match;
    o_k   = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (w_match[i]) o_k = 4'(i);
    end
  end

endmodule

// File: rtl/example_word_aligner.sv
// K28.5 word aligner: finds the comma bit offset, locks it with hysteresis, emits aligned words.
// One-cycle registered datapath; no backpressure, one raw word accepted every slowClk.
module example_word_aligner
  import example_word_aligner_pkg::*;
#(
  parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
  parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF,
  parameter int MAX_GAP      = MAX_GAP_DEF
) (
  input  logic       slowClk,
  input  logic       resetN,
  input  logic [9:0] data_rx,
  input  logic       relock,
  output logic [9:0] dataOut,
  output logic       commaOut,
  output logic       dataValid,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lockLoss
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam int ERR_W = $clog2(UNLOCK_COUNT + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  state_t             r_state, w_state_nxt;
  logic [9:0]         r_prev;
  logic [3:0]         r_offset, w_offset_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ERR_W-1:0]   r_err, w_err_nxt, w_err_inc;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt, w_gap_inc;
  logic               w_gap_exp;
  logic [19:0]        w_win;
  logic               w_hit, w_at_off;
  logic [3:0]         w_k;
  logic [9:0]         w_cand;
  logic               r_locked, r_lock_loss, r_comma;
  logic [9:0]         r_data;

  assign w_win = {r_prev, data_rx};

  example_comma_finder u_finder (
    .i_win (w_win),
    .o_hit (w_hit),
    .o_k   (w_k)
  );

  assign w_at_off  = w_hit && (w_k == r_offset);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_err_inc = r_err + ERR_W'(1);
  assign w_gap_inc = (r_gap == GAP_W'(MAX_GAP)) ? r_gap : r_gap + GAP_W'(1);
  assign w_gap_exp = (w_gap_inc == GAP_W'(MAX_GAP));

  // Output word uses the offset held before this edge, not the one being found now.
  assign w_cand = cand_at(w_win, r_offset);

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    w_gap_nxt    = r_gap;
    case (r_state)
      HUNT: begin
        if (w_hit) begin
          w_offset_nxt = w_k;
          w_cnt_nxt    = CNT_W'(1);
          w_gap_nxt    = '0;
          w_state_nxt  = (LOCK_COUNT == 1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (w_at_off) begin
          w_cnt_nxt = w_cnt_inc;
          w_gap_nxt = '0;
          if (w_cnt_inc == CNT_W'(LOCK_COUNT)) w_state_nxt = LOCKED;
        end else if (w_hit) begin
          w_offset_nxt = w_k;
          w_cnt_nxt    = CNT_W'(1);
          w_gap_nxt    = '0;
        end else begin
          w_gap_nxt = w_gap_inc;
          if (w_gap_exp) w_state_nxt = HUNT;
        end
      end
      LOCKED: begin
        if (w_at_off) begin
          w_err_nxt = '0;
          w_gap_nxt = '0;
        end else begin
          // A wrong-offset comma still counts as a gap cycle for the held offset.
          w_gap_nxt = w_gap_inc;
          if (w_hit) w_err_nxt = w_err_inc;
          if ((w_hit && (w_err_inc == ERR_W'(UNLOCK_COUNT))) || w_gap_exp) w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase

    if (relock) begin
      w_state_nxt  = HUNT;
      w_offset_nxt = r_offset;
    end

    if (w_state_nxt == HUNT) begin
      w_cnt_nxt = '0;
      w_err_nxt = '0;
      w_gap_nxt = '0;
    end
  end

  always_ff @(posedge slowClk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= HUNT;
      r_prev   <= '0;
      r_offset <= '0;
      r_cnt    <= '0;
      r_err    <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= data_rx;
      r_offset <= w_offset_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  always_ff @(posedge slowClk or negedge resetN) begin
    if (!resetN) begin
      r_data      <= '0;
      r_comma     <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_loss <= 1'b0;
    end else begin
      r_data      <= w_cand;
      r_comma     <= is_comma(w_cand);
      r_locked    <= (w_state_nxt == LOCKED);
      r_lock_loss <= (r_state == LOCKED) && (w_state_nxt == HUNT);
    end
  end

  assign dataOut   = r_data;
  assign commaOut  = r_comma;
  assign locked    = r_locked;
  assign dataValid = r_locked;
  assign offset    = r_offset;
  assign lockLoss  = r_lock_loss;

endmodule
